// File: rtl/timer_compare_unit.sv
// Tick-driven compare timer: WIDTH-bit counter, compare match, one-shot mode, W1C status, level irq.
// Defining TIMER_CAPTURE_EN adds the cap_in port with a synchronised input-capture register.
module timer_compare_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic        cap_in
`endif
);

    localparam logic [4:0] ADDR_CTRL    = 5'h00;
    localparam logic [4:0] ADDR_COUNT   = 5'h04;
    localparam logic [4:0] ADDR_CMP     = 5'h08;
    localparam logic [4:0] ADDR_STATUS  = 5'h0C;
    localparam logic [4:0] ADDR_CAPTURE = 5'h10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_cmp;
    logic             r_match;
    logic             r_done;
    logic [1:0]       r_state;
    logic [31:0]      r_rdata;

    logic [2:0]       w_ctrl_d;
    logic [WIDTH-1:0] w_count_d;
    logic             w_match_d;
    logic             w_done_d;
    logic [1:0]       w_state_d;
    logic [31:0]      w_rdata_d;

    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_cmp;
    logic             w_wr_status;
    logic [2:0]       w_clr;
    logic             w_run_tick;
    logic             w_hit;
    logic             w_match_set;
    logic             w_done_set;

    logic             w_cap_flag;
    logic [WIDTH-1:0] w_capture_val;

    logic [31:0]      w_count_ext;
    logic [31:0]      w_cmp_ext;
    logic [31:0]      w_capture_ext;
    logic             w_unused_wdata;

    assign w_wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL);
    assign w_wr_count  = bus_we && (bus_addr == ADDR_COUNT);
    assign w_wr_cmp    = bus_we && (bus_addr == ADDR_CMP);
    assign w_wr_status = bus_we && (bus_addr == ADDR_STATUS);
    assign w_clr       = w_wr_status ? bus_wdata[2:0] : 3'b000;

    // A same-cycle COUNT write drops the tick entirely, flags included.
    assign w_run_tick  = (r_state == ST_RUN) && tick && !w_wr_count;
    assign w_hit       = (r_count == r_cmp);
    assign w_match_set = w_run_tick && w_hit;
    assign w_done_set  = w_match_set && r_ctrl[1];

    assign w_unused_wdata = ^{bus_wdata, w_clr};

    always_comb begin
        w_count_d = r_count;
        if (w_wr_count) begin
            w_count_d = bus_wdata[WIDTH-1:0];
        end else if (w_run_tick) begin
            w_count_d = w_hit ? '0 : (r_count + COUNT_ONE);
        end
    end

    // A software CTRL write overrides the hardware EN clear of a one-shot completion.
    always_comb begin
        w_ctrl_d = r_ctrl;
        if (w_wr_ctrl) begin
            w_ctrl_d = bus_wdata[2:0];
        end else if (w_done_set) begin
            w_ctrl_d[0] = 1'b0;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE, ST_STOP: begin
                if (w_ctrl_d[0]) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_ctrl_d[0]) begin
                    w_state_d = w_done_set ? ST_STOP : ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_match_d = w_match_set | (r_match & ~w_clr[0]);
    assign w_done_d  = w_done_set  | (r_done  & ~w_clr[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl  <= 3'b000;
            r_count <= '0;
            r_cmp   <= '0;
            r_match <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_ctrl  <= w_ctrl_d;
            r_count <= w_count_d;
            if (w_wr_cmp) begin
                r_cmp <= bus_wdata[WIDTH-1:0];
            end
            r_match <= w_match_d;
            r_done  <= w_done_d;
            r_state <= w_state_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [1:0]       r_cap_sync;
    logic             r_cap_prev;
    logic             r_cap;
    logic [WIDTH-1:0] r_capture;
    logic             w_cap_edge;

    assign w_cap_edge = r_cap_sync[1] & ~r_cap_prev;

    // Captures the pre-tick COUNT, independent of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_sync <= 2'b00;
            r_cap_prev <= 1'b0;
            r_cap      <= 1'b0;
            r_capture  <= '0;
        end else begin
            r_cap_sync <= {r_cap_sync[0], cap_in};
            r_cap_prev <= r_cap_sync[1];
            r_cap      <= w_cap_edge | (r_cap & ~w_clr[2]);
            if (w_cap_edge) begin
                r_capture <= r_count;
            end
        end
    end

    assign w_cap_flag    = r_cap;
    assign w_capture_val = r_capture;
`else
    assign w_cap_flag    = 1'b0;
    assign w_capture_val = '0;
`endif

    always_comb begin
        w_count_ext                = '0;
        w_cmp_ext                  = '0;
        w_capture_ext              = '0;
        w_count_ext[WIDTH-1:0]     = r_count;
        w_cmp_ext[WIDTH-1:0]       = r_cmp;
        w_capture_ext[WIDTH-1:0]   = w_capture_val;
    end

    always_comb begin
        w_rdata_d = '0;
        case (bus_addr)
            ADDR_CTRL:    w_rdata_d = {29'd0, r_ctrl};
            ADDR_COUNT:   w_rdata_d = w_count_ext;
            ADDR_CMP:     w_rdata_d = w_cmp_ext;
            ADDR_STATUS:  w_rdata_d = {29'd0, w_cap_flag, r_done, r_match};
            ADDR_CAPTURE: w_rdata_d = w_capture_ext;
            default:      w_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (bus_re) begin
            r_rdata <= w_rdata_d;
        end
    end

    assign bus_rdata = r_rdata;
    assign irq       = r_ctrl[2] & (r_match | w_cap_flag);

endmodule
